// File: rtl/stack_pkg.sv
// Shared constants and command decode for the hardware LIFO stack.
// The pointer is one bit wider than the address so that sp can reach DEPTH.
package stack_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 16;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int PTR_W = ptr_w(DEPTH_DEF);

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_PUSH  = 3'd1,
      CMD_POP   = 3'd2,
      CMD_TOS   = 3'd3,
      CMD_MULTI = 3'd4
   } cmd_e;

   // Any combination with more than one command bit set is illegal.
   function automatic cmd_e decode_cmd(input logic push, input logic pop, input logic tos);
      cmd_e c;
      case ({push, pop, tos})
         3'b000:  c = CMD_NONE;
         3'b100:  c = CMD_PUSH;
         3'b010:  c = CMD_POP;
         3'b001:  c = CMD_TOS;
         default: c = CMD_MULTI;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hw_stack_if.sv
// Command/data bundle between a stack user (master) and hw_stack (slave).
interface hw_stack_if
   import stack_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
);
   logic                    push;
   logic                    pop;
   logic                    tos;
   logic [WIDTH-1:0]        d_in;
   logic [WIDTH-1:0]        d_out;
   logic [ptr_w(DEPTH)-1:0] count;
   logic                    empty;
   logic                    full;
   logic                    ovf;
   logic                    udf;
   logic                    cmd_err;

   modport master (
      output push, pop, tos, d_in,
      input  d_out, count, empty, full, ovf, udf, cmd_err
   );

   modport slave (
      input  push, pop, tos, d_in,
      output d_out, count, empty, full, ovf, udf, cmd_err
   );
endinterface

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the stack pointer alone decides validity.
module stack_mem
   import stack_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];
endmodule

// File: rtl/hw_stack.sv
// LIFO stack: push/pop/tos control, stack pointer, registered read data
// and sticky error flags (overflow, underflow, illegal command combination).
module hw_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic      clk,
   input  logic      rst,
   hw_stack_if.slave bus
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW-1:0] SP_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] SP_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);

   logic [PW-1:0]    sp_r, sp_nxt_s;
   logic [WIDTH-1:0] d_out_r, d_out_nxt_s, rd_data_s;
   logic             ovf_r, udf_r, cmd_err_r;
   logic             ovf_set_s, udf_set_s, err_set_s;
   logic             wr_en_s, mem_we_s;
   logic             empty_s, full_s;
   logic [AW-1:0]    wr_addr_s, rd_addr_s;
   cmd_e             cmd_s;

   assign cmd_s     = decode_cmd(bus.push, bus.pop, bus.tos);
   assign empty_s   = (sp_r == SP_ZERO);
   assign full_s    = (sp_r == SP_FULL);
   assign wr_addr_s = sp_r[AW-1:0];
   assign rd_addr_s = AW'(sp_r - SP_ONE);
   assign mem_we_s  = wr_en_s & ~rst;

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (wr_addr_s),
      .wdata (bus.d_in),
      .raddr (rd_addr_s),
      .rdata (rd_data_s)
   );

   // Next-state decode: guards keep sp inside 0..DEPTH, errors leave state untouched
   always_comb begin
      sp_nxt_s    = sp_r;
      d_out_nxt_s = d_out_r;
      wr_en_s     = 1'b0;
      ovf_set_s   = 1'b0;
      udf_set_s   = 1'b0;
      err_set_s   = 1'b0;
      case (cmd_s)
         CMD_NONE: begin
            sp_nxt_s = sp_r;
         end
         CMD_PUSH: begin
            if (full_s) begin
               ovf_set_s = 1'b1;
            end else begin
               wr_en_s  = 1'b1;
               sp_nxt_s = sp_r + SP_ONE;
            end
         end
         CMD_POP: begin
            if (empty_s) begin
               udf_set_s = 1'b1;
            end else begin
               d_out_nxt_s = rd_data_s;
               sp_nxt_s    = sp_r - SP_ONE;
            end
         end
         CMD_TOS: begin
            if (empty_s) begin
               udf_set_s = 1'b1;
            end else begin
               d_out_nxt_s = rd_data_s;
            end
         end
         CMD_MULTI: begin
            err_set_s = 1'b1;
         end
         default: begin
            err_set_s = 1'b1;
         end
      endcase
   end

   // Pointer, read data and sticky flags; reset overrides any command
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_r      <= SP_ZERO;
         d_out_r   <= {WIDTH{1'b0}};
         ovf_r     <= 1'b0;
         udf_r     <= 1'b0;
         cmd_err_r <= 1'b0;
      end else begin
         sp_r      <= sp_nxt_s;
         d_out_r   <= d_out_nxt_s;
         ovf_r     <= ovf_r | ovf_set_s;
         udf_r     <= udf_r | udf_set_s;
         cmd_err_r <= cmd_err_r | err_set_s;
      end
   end

   assign bus.d_out   = d_out_r;
   assign bus.count   = sp_r;
   assign bus.empty   = empty_s;
   assign bus.full    = full_s;
   assign bus.ovf     = ovf_r;
   assign bus.udf     = udf_r;
   assign bus.cmd_err = cmd_err_r;
endmodule

// File: doc/hw_stack.md
HW_STACK -- requirements
Module: hw_stack

Interface
REQ-001 Parameter WIDTH, default 8, is the data word width in bits.
REQ-002 Parameter DEPTH, default 16, is the number of stack entries; it SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 push  input  1  write d_in onto the top of the stack.
REQ-006 pop  input  1  read the top entry to d_out and remove it.
REQ-007 tos  input  1  read the top entry to d_out without removing it.
REQ-008 d_in  input  WIDTH  data to push.
REQ-009 d_out  output  WIDTH  registered read data.
REQ-010 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 empty  output  1  high when count==0.
REQ-012 full  output  1  high when count==DEPTH.
REQ-013 ovf  output  1  sticky flag: a push was attempted while full.
REQ-014 udf  output  1  sticky flag: a pop or tos was attempted while empty.
REQ-015 cmd_err  output  1  sticky flag: more than one of push, pop and tos was high in the same cycle.

Function
REQ-016 Stack pointer sp (0..DEPTH) SHALL point to the next free slot, and count SHALL equal sp.
REQ-017 Valid push, not full: mem[sp] <= d_in and sp <= sp+1 on the same edge; d_out unchanged.
REQ-018 Valid pop, not empty: d_out <= mem[sp-1] and sp <= sp-1 on the same edge.
REQ-019 Valid tos, not empty: d_out <= mem[sp-1]; sp unchanged.
REQ-020 Read latency SHALL be one cycle: d_out is valid in the cycle after the pop/tos cycle and holds until the next valid pop/tos or reset.
REQ-021 Push while full: memory, sp and d_out unchanged; ovf <= 1.
REQ-022 Pop or tos while empty: sp and d_out unchanged; udf <= 1.
REQ-023 Two or more commands high in one cycle: no change to memory, sp or d_out; cmd_err <= 1.
REQ-024 No command: all state held.
REQ-025 Back-to-back commands on consecutive cycles SHALL each be accepted, with no bubble cycle required.
REQ-026 Push then pop on consecutive cycles SHALL return the pushed value.
REQ-027 empty and full SHALL be combinational decodes of sp, reflecting the post-edge sp.
REQ-028 ovf, udf and cmd_err SHALL clear only on reset.
REQ-029 sp arithmetic is unsigned; it SHALL never wrap, because the guards in REQ-021 and REQ-022 prevent it.

Reset
REQ-030 When rst is high at a clock edge: sp=0, d_out=0, ovf=0, udf=0, cmd_err=0; empty=1, full=0.
REQ-031 Reset SHALL take priority over any command in the same cycle.
REQ-032 A reset in the middle of a command sequence SHALL discard all entries logically.
REQ-033 Memory contents SHALL NOT be reset and are don't-care after reset.

Structure
REQ-034 The shared package stack_pkg SHALL hold WIDTH/DEPTH defaults and the pointer-width constant.
REQ-035 The storage array SHALL be a sub-module stack_mem: one synchronous write port, one asynchronous read port addressed by sp-1.
REQ-036 The control and pointer logic SHALL live in hw_stack, with no additional FSM beyond sp and the flags.

Verification
REQ-037 After reset: push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3 -> d_out 0x33, 0x22, 0x11 on the following cycles; empty=1 at the end.
REQ-038 Push 0xA5, tos, tos -> d_out=0xA5 both times, count stays 1; then pop -> d_out=0xA5, count=0.
REQ-039 Push 16 values (DEPTH=16) -> full=1; a 17th push of 0xFF -> ovf=1, count=16, and popping returns the 16th value, not 0xFF.
REQ-040 Pop while empty -> udf=1, d_out keeps its previous value, count=0; tos while empty behaves the same.
REQ-041 push and pop both high with count=2 -> cmd_err=1, count=2, d_out unchanged.
REQ-042 Push x3, then rst for one cycle together with a pop -> count=0, d_out=0, all flags 0; a following tos -> udf=1.
